// File: rtl/grayscale.sv
// RGB-to-gray front end: pops 24-bit pixels, writes (R+G+B)/3 through a
// single-entry holding register, and pulses done after each frame's last write.
module grayscale #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [23:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [7:0]  out_din,
  output logic        done
);

  // state  | meaning
  // S_RUN  | converting pixels of the current frame
  // S_DONE | one-cycle frame end: done high, counters cleared
  typedef enum logic {S_RUN, S_DONE} state_t;

  localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW         = $clog2(NUM_PIXELS + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(NUM_PIXELS - 1);
  localparam logic [CW-1:0] NUM_PIX  = CW'(NUM_PIXELS);

  state_t        state_q, state_d;
  logic          hv_q, hv_d;
  logic [7:0]    hold_q, hold_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          done_q, done_d;

  logic       wr, rd;
  logic [9:0] sum;
  logic [9:0] quot;

  assign sum  = {2'b00, in_dout[23:16]} + {2'b00, in_dout[15:8]} + {2'b00, in_dout[7:0]};
  assign quot = sum / 10'd3;

  assign wr = (state_q == S_RUN) & hv_q & ~out_full;
  assign rd = (state_q == S_RUN) & ~in_empty & (in_cnt_q < NUM_PIX) & (~hv_q | wr);

  assign in_rd_en  = rd;
  assign out_wr_en = wr;
  assign out_din   = hv_q ? hold_q : 8'd0;
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    hv_d      = hv_q;
    hold_d    = hold_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_RUN: begin
        // a simultaneous pop and push replaces the entry in place
        if (rd) begin
          hold_d = quot[7:0];
          hv_d   = 1'b1;
        end else if (wr) begin
          hv_d = 1'b0;
        end
        if (rd) in_cnt_d = in_cnt_q + 1'b1;
        if (wr) out_cnt_d = out_cnt_q + 1'b1;
        if (wr && (out_cnt_q == LAST_PIX)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_RUN;
      hv_q      <= 1'b0;
      hold_q    <= 8'd0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hv_q      <= hv_d;
      hold_q    <= hold_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_grayscale.sv
// Bench for grayscale: a 4x3 instance driven from a modelled RGB FIFO with
// random bubbles/stalls, plus a 1x1 instance for single-pixel frames.
module tb_grayscale;

  localparam int NP = 12;

  logic        clock;
  logic        reset;
  logic        in_rd_en, in_empty, out_wr_en, out_full, done;
  logic [23:0] in_dout;
  logic [7:0]  out_din;

  logic        reset1;
  logic        in_rd_en1, in_empty1, out_wr_en1, out_full1, done1;
  logic [23:0] in_dout1;
  logic [7:0]  out_din1;

  int checks = 0;
  int errors = 0;

  logic [23:0] inq[$];
  int          exp_q[$];
  int          pops_f = 0, writes_f = 0, frames = 0, n_done = 0, cyc = 0;
  bit          exp_done = 0;

  grayscale #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
    .clock(clock), .reset(reset), .in_rd_en(in_rd_en), .in_empty(in_empty),
    .in_dout(in_dout), .out_wr_en(out_wr_en), .out_full(out_full),
    .out_din(out_din), .done(done)
  );

  grayscale #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut1 (
    .clock(clock), .reset(reset1), .in_rd_en(in_rd_en1), .in_empty(in_empty1),
    .in_dout(in_dout1), .out_wr_en(out_wr_en1), .out_full(out_full1),
    .out_din(out_din1), .done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input int r, input int g, input int b);
    inq.push_back({r[7:0], g[7:0], b[7:0]});
    exp_q.push_back((r + g + b) / 3);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++)
      push($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  // One clock of the main DUT against the FIFO/occupancy model.
  task automatic cycle(input bit stall_i, input int bub_i);
    int pending;
    bit ewr, erd;
    in_empty = (inq.size() == 0) || ($urandom_range(0, 99) < bub_i);
    in_dout  = (inq.size() != 0) ? inq[0] : 24'($urandom);
    out_full = stall_i;
    #1;
    pending = pops_f - writes_f;
    ewr = !exp_done && (pending > 0) && !out_full;
    erd = !exp_done && !in_empty && (pops_f < NP) && (pending == 0 || ewr);
    check("done", done, exp_done);
    check("out_wr_en", out_wr_en, ewr);
    check("in_rd_en", in_rd_en, erd);
    check("out_din", out_din, (pending > 0) ? exp_q[0] : 0);
    if (done) n_done++;
    if (exp_done) begin
      pops_f = 0; writes_f = 0; exp_done = 0; frames++;
    end else begin
      if (ewr) begin
        void'(exp_q.pop_front());
        writes_f++;
        if (writes_f == NP) exp_done = 1;
      end
      if (erd) begin
        void'(inq.pop_front());
        pops_f++;
      end
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic run_frame(input int stall_from, input int stall_len, input int bub, output int k);
    int f0;
    f0 = frames;
    k = 0;
    while (frames == f0 && k < 400) begin
      cycle(k >= stall_from && k < stall_from + stall_len, bub);
      k++;
    end
    check("frame_complete", (frames != f0), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_empty = 1'b1; out_full = 1'b0;
    @(posedge clock); #1;
    check("rst_in_rd_en", in_rd_en, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_out_din", out_din, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    inq.delete(); exp_q.delete();
    pops_f = 0; writes_f = 0; exp_done = 0;
  endtask

  initial begin
    int k;
    reset = 1'b1; in_empty = 1'b1; in_dout = '0; out_full = 1'b0;
    reset1 = 1'b1; in_empty1 = 1'b1; in_dout1 = '0; out_full1 = 1'b0;

    // single-pixel frames on the 1x1 instance
    @(posedge clock); #1;
    check("p1_rst_rd", in_rd_en1, 0);
    check("p1_rst_wr", out_wr_en1, 0);
    check("p1_rst_din", out_din1, 0);
    check("p1_rst_done", done1, 0);
    reset1 = 1'b0; in_empty1 = 1'b0; in_dout1 = {8'd200, 8'd100, 8'd50};
    #1 check("p1_rd", in_rd_en1, 1);
    @(posedge clock); #1; in_empty1 = 1'b1; #1;
    check("p1_wr", out_wr_en1, 1);
    check("p1_din", out_din1, 116);
    check("p1_done_early", done1, 0);
    @(posedge clock); #1;
    check("p1_done", done1, 1);
    check("p1_wr_in_done", out_wr_en1, 0);
    in_empty1 = 1'b0; in_dout1 = {8'd0, 8'd0, 8'd1}; #1;
    check("p1_rd_in_done", in_rd_en1, 0);
    @(posedge clock); #1;
    check("p1_done_low", done1, 0);
    check("p1_rd2", in_rd_en1, 1);
    @(posedge clock); #1; in_empty1 = 1'b1; #1;
    check("p1_din2", out_din1, 0);
    check("p1_wr2", out_wr_en1, 1);
    @(posedge clock); #1;
    check("p1_done2", done1, 1);

    // full frame of R=G=B=k plus one pixel of the next frame
    do_reset();
    for (int i = 0; i < NP; i++) push(i, i, i);
    push(90, 60, 30);
    run_frame(1000, 0, 0, k);
    check("frame_period", k, NP + 2);

    // backpressure for 5 cycles mid-frame
    push_rand(NP - 1);
    run_frame(4, 5, 0, k);

    // random input bubbles
    push_rand(NP);
    run_frame(1000, 0, 50, k);

    // extremes
    push(255, 255, 255); push(0, 0, 0); push(0, 0, 2); push(1, 1, 1); push(255, 255, 254);
    push(10, 20, 31); push(200, 100, 50); push(0, 0, 1);
    push_rand(NP - 8);
    run_frame(1000, 0, 20, k);

    // reset mid-frame with a held pixel
    push_rand(NP);
    k = 0;
    while (writes_f < 5 && k < 100) begin cycle(0, 0); k++; end
    check("held_before_reset", out_wr_en, 1);
    do_reset();
    push_rand(NP);
    run_frame(3, 2, 30, k);

    // mixed random stalls and bubbles over two frames
    push_rand(2 * NP);
    k = 0;
    while (frames < 7 && k < 1000) begin cycle($urandom_range(0, 99) < 30, 30); k++; end
    check("frames_done", frames, 7);
    for (int i = 0; i < 3; i++) cycle(0, 0);
    check("done_pulses", n_done, frames);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
